// File: rtl/alu_shift_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_shift_pipe_if
//   Bundles the request and result handshakes of the alu_shift_pipe shifter.
//
//   Request side : in_valid, in_ready, in_op[2:0], in_data[63:0],
//                  in_shamt[5:0], in_tag[TAG_W-1:0]
//   Result side  : out_valid, out_ready, out_result[63:0],
//                  out_tag[TAG_W-1:0], out_illegal
//   Status       : op_count[31:0] (results delivered since reset)
//
//   modport master : the producer/consumer environment around the block
//   modport slave  : the shifter pipeline itself
// ---------------------------------------------------------------------------
interface alu_shift_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [63:0]      in_data;
    logic [5:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [31:0]      op_count;

    modport master (
        output in_valid,
        output in_op,
        output in_data,
        output in_shamt,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_tag,
        input  out_illegal,
        input  op_count
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_data,
        input  in_shamt,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_tag,
        output out_illegal,
        output op_count
    );
endinterface

// File: rtl/alu_shift_pipe.sv
// ---------------------------------------------------------------------------
// alu_shift_pipe
//   Two-stage valid/ready pipelined 64-bit shifter (RV64 SLL/SRL/SRA and the
//   32-bit W variants). S1 registers the accepted request, the shift is
//   computed combinationally from S1, and S2 registers the result.
//
//   Ports
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset (overrides everything)
//     flush : synchronous discard of all in-flight operations
//     bus   : alu_shift_pipe_if.slave
//               in_op encoding: 000 SLL, 001 SRL, 010 SRA,
//                               100 SLLW, 101 SRLW, 110 SRAW,
//                               011/111 illegal (result 0, out_illegal 1)
// ---------------------------------------------------------------------------
module alu_shift_pipe #(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_shift_pipe_if.slave   bus
);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Mirror a 64-bit word so a right shifter can also produce left shifts.
    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[63 - i];
        end
        return r;
    endfunction

    // Six-layer 2:1 mux right shifter; each layer shifts by a power of two
    // and back-fills with the sign bit when arith is set.
    function automatic logic [63:0] shr64(input logic [63:0] v,
                                          input logic [5:0]  amt,
                                          input logic        arith);
        logic        fill;
        logic [63:0] l1;
        logic [63:0] l2;
        logic [63:0] l3;
        logic [63:0] l4;
        logic [63:0] l5;
        logic [63:0] l6;
        fill = arith & v[63];
        l1 = amt[0] ? {fill,          v[63:1]}   : v;
        l2 = amt[1] ? {{2{fill}},     l1[63:2]}  : l1;
        l3 = amt[2] ? {{4{fill}},     l2[63:4]}  : l2;
        l4 = amt[3] ? {{8{fill}},     l3[63:8]}  : l3;
        l5 = amt[4] ? {{16{fill}},    l4[63:16]} : l4;
        l6 = amt[5] ? {{32{fill}},    l5[63:32]} : l5;
        return l6;
    endfunction

    // Sign-extend the low word into a full 64-bit value.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             s1_valid_q,  s1_valid_d;
    logic [2:0]       s1_op_q,     s1_op_d;
    logic [63:0]      s1_data_q,   s1_data_d;
    logic [5:0]       s1_shamt_q,  s1_shamt_d;
    logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;

    logic             s2_valid_q,   s2_valid_d;
    logic [63:0]      s2_result_q,  s2_result_d;
    logic [TAG_W-1:0] s2_tag_q,     s2_tag_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic [31:0]      op_count_q,   op_count_d;

    // -----------------------------------------------------------------------
    // Handshake terms
    // -----------------------------------------------------------------------
    logic s1_adv_s;
    logic in_ready_s;
    logic deliver_s;

    // S1 may move forward when S2 is empty or is being drained this cycle.
    assign s1_adv_s   = !s2_valid_q || bus.out_ready;
    // in_ready never looks at in_valid; flush blocks acceptance outright.
    assign in_ready_s = !flush && (!s1_valid_q || s1_adv_s);
    // A result handed out on a flush edge is discarded, so it is not counted.
    assign deliver_s  = s2_valid_q && bus.out_ready && !flush;

    // -----------------------------------------------------------------------
    // Shift datapath between S1 and S2
    // -----------------------------------------------------------------------
    logic        is_word_s;
    logic [5:0]  amt_s;
    logic [63:0] src_s;
    logic [63:0] raw_s;
    logic        illegal_s;
    logic [63:0] result_s;

    // Select operand/amount, run the shared right shifter, fix up W results.
    always_comb begin
        is_word_s = s1_op_q[2];
        amt_s     = is_word_s ? {1'b0, s1_shamt_q[4:0]} : s1_shamt_q;
        src_s     = s1_data_q;
        raw_s     = 64'd0;
        illegal_s = 1'b0;
        case (s1_op_q[1:0])
            2'b00: begin
                // Left shift is reverse / shift right / reverse.
                src_s = s1_data_q;
                raw_s = rev64(shr64(rev64(src_s), amt_s, 1'b0));
            end
            2'b01: begin
                src_s = is_word_s ? {32'd0, s1_data_q[31:0]} : s1_data_q;
                raw_s = shr64(src_s, amt_s, 1'b0);
            end
            2'b10: begin
                src_s = is_word_s ? sext32(s1_data_q[31:0]) : s1_data_q;
                raw_s = shr64(src_s, amt_s, 1'b1);
            end
            default: begin
                raw_s     = 64'd0;
                illegal_s = 1'b1;
            end
        endcase
        // W results keep only the low word, sign-extended from bit 31.
        if (is_word_s) begin
            result_s = sext32(raw_s[31:0]);
        end else begin
            result_s = raw_s;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------

    // Pipeline advance, acceptance, flush and delivery counting.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_data_d    = s1_data_q;
        s1_shamt_d   = s1_shamt_q;
        s1_tag_d     = s1_tag_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_tag_d     = s2_tag_q;
        s2_illegal_d = s2_illegal_q;
        op_count_d   = op_count_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            // S2 takes S1 (or empties); payload only changes when S1 holds
            // an op, so a stalled result stays put.
            if (s1_adv_s) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d  = result_s;
                    s2_tag_d     = s1_tag_q;
                    s2_illegal_d = illegal_s;
                end else begin
                    s2_result_d  = s2_result_q;
                end
            end else begin
                s2_valid_d = s2_valid_q;
            end

            // S1 refills on the same edge it drains, so no bubble appears.
            if (in_ready_s) begin
                s1_valid_d = bus.in_valid;
                if (bus.in_valid) begin
                    s1_op_d    = bus.in_op;
                    s1_data_d  = bus.in_data;
                    s1_shamt_d = bus.in_shamt;
                    s1_tag_d   = bus.in_tag;
                end else begin
                    s1_op_d    = s1_op_q;
                end
            end else begin
                s1_valid_d = s1_valid_q;
            end

            if (deliver_s) begin
                op_count_d = op_count_q + 32'd1;
            end else begin
                op_count_d = op_count_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 3'd0;
            s1_data_q    <= 64'd0;
            s1_shamt_q   <= 6'd0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 64'd0;
            s2_tag_q     <= '0;
            s2_illegal_q <= 1'b0;
            op_count_q   <= 32'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_data_q    <= s1_data_d;
            s1_shamt_q   <= s1_shamt_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_tag_q     <= s2_tag_d;
            s2_illegal_q <= s2_illegal_d;
            op_count_q   <= op_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_result  = s2_result_q;
    assign bus.out_tag     = s2_tag_q;
    assign bus.out_illegal = s2_illegal_q;
    assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_alu_shift_pipe.sv
module tb_alu_shift_pipe;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_shift_pipe_if #(.TAG_W(TAG_W)) bus ();

    alu_shift_pipe #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_count   = 32'd0;

    // Directed shift vectors
    logic [2:0]  sv_op    [0:11];
    logic [63:0] sv_data  [0:11];
    logic [5:0]  sv_shamt [0:11];
    logic [63:0] sv_exp   [0:11];

    // Back-to-back requests
    logic [2:0]       bb_op    [0:3];
    logic [63:0]      bb_data  [0:3];
    logic [5:0]       bb_shamt [0:3];
    logic [TAG_W-1:0] bb_tag   [0:3];
    logic [63:0]      bb_exp   [0:3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_data   = 64'd0;
        bus.in_shamt  = 6'd0;
        bus.in_tag    = '0;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [63:0] data,
                             input logic [5:0] shamt, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
    endtask

    // Present one request for one edge on an idle pipeline, then go idle.
    task automatic issue(input logic [2:0] op, input logic [63:0] data,
                         input logic [5:0] shamt, input logic [TAG_W-1:0] tag);
        drive_req(op, data, shamt, tag);
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; drive_idle(); bus.out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (bus.out_result !== 64'd0) begin miscompares++; $display("FAIL rst_out_result got=%h exp=0", bus.out_result); end
        vectors++; if (bus.out_tag !== 5'd0) begin miscompares++; $display("FAIL rst_out_tag got=%h exp=0", bus.out_tag); end
        vectors++; if (bus.out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_out_illegal got=%b exp=0", bus.out_illegal); end
        vectors++; if (bus.op_count !== 32'd0) begin miscompares++; $display("FAIL rst_op_count got=%0d exp=0", bus.op_count); end
        exp_count = 32'd0;
    endtask

    task automatic test_shifts();
        logic [TAG_W-1:0] tag;
        sv_op[0]  = 3'b010; sv_data[0]  = 64'h8000_0000_0000_0000; sv_shamt[0]  = 6'd63; sv_exp[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
        sv_op[1]  = 3'b101; sv_data[1]  = 64'hFFFF_FFFF_8000_0000; sv_shamt[1]  = 6'h3F; sv_exp[1]  = 64'h0000_0000_0000_0001;
        sv_op[2]  = 3'b110; sv_data[2]  = 64'hFFFF_FFFF_8000_0000; sv_shamt[2]  = 6'h3F; sv_exp[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
        sv_op[3]  = 3'b100; sv_data[3]  = 64'h0000_0000_0000_0001; sv_shamt[3]  = 6'd31; sv_exp[3]  = 64'hFFFF_FFFF_8000_0000;
        sv_op[4]  = 3'b000; sv_data[4]  = 64'h0000_0000_0000_0001; sv_shamt[4]  = 6'd63; sv_exp[4]  = 64'h8000_0000_0000_0000;
        sv_op[5]  = 3'b001; sv_data[5]  = 64'h8000_0000_0000_0000; sv_shamt[5]  = 6'd0;  sv_exp[5]  = 64'h8000_0000_0000_0000;
        sv_op[6]  = 3'b001; sv_data[6]  = 64'hFEDC_BA98_7654_3210; sv_shamt[6]  = 6'd36; sv_exp[6]  = 64'h0000_0000_0FED_CBA9;
        sv_op[7]  = 3'b010; sv_data[7]  = 64'hFEDC_BA98_7654_3210; sv_shamt[7]  = 6'd4;  sv_exp[7]  = 64'hFFED_CBA9_8765_4321;
        sv_op[8]  = 3'b000; sv_data[8]  = 64'h0123_4567_89AB_CDEF; sv_shamt[8]  = 6'd8;  sv_exp[8]  = 64'h2345_6789_ABCD_EF00;
        sv_op[9]  = 3'b100; sv_data[9]  = 64'h0000_0000_1234_5678; sv_shamt[9]  = 6'h24; sv_exp[9]  = 64'h0000_0000_2345_6780;
        sv_op[10] = 3'b101; sv_data[10] = 64'hFFFF_FFFF_0000_0010; sv_shamt[10] = 6'd4;  sv_exp[10] = 64'h0000_0000_0000_0001;
        sv_op[11] = 3'b110; sv_data[11] = 64'h0000_0000_7000_0000; sv_shamt[11] = 6'd4;  sv_exp[11] = 64'h0000_0000_0700_0000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tag = TAG_W'(i + 3);
            issue(sv_op[i], sv_data[i], sv_shamt[i], tag);
            step();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL shift%0d_out_valid got=%b exp=1", i, bus.out_valid); end
            vectors++; if (bus.out_result !== sv_exp[i]) begin miscompares++; $display("FAIL shift%0d_result got=%h exp=%h", i, bus.out_result, sv_exp[i]); end
            vectors++; if (bus.out_tag !== tag) begin miscompares++; $display("FAIL shift%0d_tag got=%h exp=%h", i, bus.out_tag, tag); end
            vectors++; if (bus.out_illegal !== 1'b0) begin miscompares++; $display("FAIL shift%0d_illegal got=%b exp=0", i, bus.out_illegal); end
            step();
            exp_count = exp_count + 32'd1;
            vectors++; if (bus.op_count !== exp_count) begin miscompares++; $display("FAIL shift%0d_op_count got=%0d exp=%0d", i, bus.op_count, exp_count); end
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL shift%0d_drained got=%b exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 3'b011 : 3'b111;
            issue(op, 64'h0000_0000_0000_1234, 6'd5, 5'd7);
            step();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL illegal%0d_out_valid got=%b exp=1", i, bus.out_valid); end
            vectors++; if (bus.out_result !== 64'd0) begin miscompares++; $display("FAIL illegal%0d_result got=%h exp=0", i, bus.out_result); end
            vectors++; if (bus.out_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal%0d_flag got=%b exp=1", i, bus.out_illegal); end
            vectors++; if (bus.out_tag !== 5'd7) begin miscompares++; $display("FAIL illegal%0d_tag got=%h exp=7", i, bus.out_tag); end
            step();
            exp_count = exp_count + 32'd1;
        end
        vectors++; if (bus.op_count !== exp_count) begin miscompares++; $display("FAIL illegal_op_count got=%0d exp=%0d", bus.op_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int   idx;
        logic acc;
        bb_op[0] = 3'b001; bb_data[0] = 64'h1111;                bb_shamt[0] = 6'd0; bb_tag[0] = 5'd1; bb_exp[0] = 64'h1111;
        bb_op[1] = 3'b000; bb_data[1] = 64'h2222;                bb_shamt[1] = 6'd4; bb_tag[1] = 5'd2; bb_exp[1] = 64'h2_2220;
        bb_op[2] = 3'b010; bb_data[2] = 64'h8000_0000_0000_0000; bb_shamt[2] = 6'd1; bb_tag[2] = 5'd3; bb_exp[2] = 64'hC000_0000_0000_0000;
        bb_op[3] = 3'b101; bb_data[3] = 64'h44;                  bb_shamt[3] = 6'd2; bb_tag[3] = 5'd4; bb_exp[3] = 64'h11;
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_req(bb_op[idx], bb_data[idx], bb_shamt[idx], bb_tag[idx]);
            #1;
            acc = bus.in_ready;
            if (c >= 2) begin
                vectors++; if (bus.out_result !== bb_exp[0]) begin miscompares++; $display("FAIL b2b_stall%0d_result got=%h exp=%h", c, bus.out_result, bb_exp[0]); end
                vectors++; if (bus.out_tag !== bb_tag[0]) begin miscompares++; $display("FAIL b2b_stall%0d_tag got=%h exp=%h", c, bus.out_tag, bb_tag[0]); end
            end
            step();
            if (acc) idx++;
        end
        vectors++; if (idx !== 2) begin miscompares++; $display("FAIL b2b_accepted got=%0d exp=2", idx); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready got=%b exp=0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_valid got=%b exp=1", bus.out_valid); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_out%0d_valid got=%b exp=1", k, bus.out_valid); end
            vectors++; if (bus.out_result !== bb_exp[k]) begin miscompares++; $display("FAIL b2b_out%0d_result got=%h exp=%h", k, bus.out_result, bb_exp[k]); end
            vectors++; if (bus.out_tag !== bb_tag[k]) begin miscompares++; $display("FAIL b2b_out%0d_tag got=%h exp=%h", k, bus.out_tag, bb_tag[k]); end
            if (idx < 4) drive_req(bb_op[idx], bb_data[idx], bb_shamt[idx], bb_tag[idx]);
            else drive_idle();
            #1;
            acc = bus.in_ready && bus.in_valid;
            step();
            if (acc) idx++;
        end
        drive_idle();
        exp_count = exp_count + 32'd4;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got=%b exp=0", bus.out_valid); end
        vectors++; if (bus.op_count !== exp_count) begin miscompares++; $display("FAIL b2b_op_count got=%0d exp=%0d", bus.op_count, exp_count); end
    endtask

    // Two ops in flight then flush (use_rst=0) or reset (use_rst=1).
    task automatic test_discard(input logic use_rst);
        bus.out_ready = 1'b0;
        drive_req(3'b001, 64'hAAAA, 6'd0, 5'd9);
        step();
        drive_req(3'b001, 64'hBBBB, 6'd0, 5'd10);
        step();
        bus.out_ready = 1'b1;
        drive_req(3'b001, 64'hCCCC, 6'd0, 5'd11);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        #1;
        if (!use_rst) begin
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
        end
        step();
        rst = 1'b0; flush = 1'b0; drive_idle();
        if (use_rst) exp_count = 32'd0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL discard%0d_out_valid got=%b exp=0", use_rst, bus.out_valid); end
        vectors++; if (bus.op_count !== exp_count) begin miscompares++; $display("FAIL discard%0d_op_count got=%0d exp=%0d", use_rst, bus.op_count, exp_count); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL discard%0d_in_ready got=%b exp=1", use_rst, bus.in_ready); end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL discard%0d_no_ghost got=%b exp=0", use_rst, bus.out_valid); end
        issue(3'b010, 64'h8000_0000_0000_0000, 6'd63, 5'd3);
        step();
        vectors++; if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL discard%0d_next_result got=%h exp=ffffffffffffffff", use_rst, bus.out_result); end
        vectors++; if (bus.out_tag !== 5'd3) begin miscompares++; $display("FAIL discard%0d_next_tag got=%h exp=3", use_rst, bus.out_tag); end
        step();
        exp_count = exp_count + 32'd1;
        vectors++; if (bus.op_count !== exp_count) begin miscompares++; $display("FAIL discard%0d_next_count got=%0d exp=%0d", use_rst, bus.op_count, exp_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_idle();
        test_reset();
        test_shifts();
        test_illegal();
        test_back_to_back();
        test_discard(1'b0);
        test_discard(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
